// File: rtl/pipeline_collect_pkg.sv
// Shared defaults for the N-to-one collect stage. The payload width is
// always a module parameter; these values only seed the defaults.
package pipeline_collect_pkg;
    localparam int PC_N_DEFAULT      = 2;
    localparam int PC_W_DEFAULT      = 32;
    localparam int PC_BYPASS_DEFAULT = 1;
endpackage

// File: rtl/pipeline_collect_slot.sv
// One-entry valid/ready holding register. The drain input empties the slot,
// and a refill in the same cycle takes priority over the drain.
module pipeline_slot
    import pipeline_collect_pkg::*;
#(
    parameter int W            = PC_W_DEFAULT,
    parameter int BYPASS_READY = PC_BYPASS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         drain,
    output logic         full,
    output logic [W-1:0] data
);
    logic         full_r;
    logic [W-1:0] data_r;
    logic         accept_s;

    // Accept while empty or, with bypass enabled, while the slot is draining.
    always_comb begin
        if (BYPASS_READY != 0) begin
            in_ready = !full_r || drain;
        end else begin
            in_ready = !full_r;
        end
        accept_s = in_valid && in_ready;
    end

    // Slot state: a refill wins over a drain, so a payload is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r <= 1'b0;
            data_r <= {W{1'b0}};
        end else if (accept_s) begin
            full_r <= 1'b1;
            data_r <= in_data;
        end else if (drain) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign full = full_r;
    assign data = data_r;
endmodule

// File: rtl/pipeline_collect.sv
// Joins N valid/ready producer lanes into one consumer transaction carrying
// all N payloads; each lane has its own one-entry slot.
module pipeline_collect
    import pipeline_collect_pkg::*;
#(
    parameter int N            = PC_N_DEFAULT,
    parameter int W            = PC_W_DEFAULT,
    parameter int BYPASS_READY = PC_BYPASS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        i_valid,
    output logic [N-1:0]        i_ready,
    input  logic [N-1:0][W-1:0] i_data,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [N-1:0][W-1:0] o_data
);
    logic [N-1:0] full_s;
    logic         fire_s;

    // o_valid depends only on slot state, never on the producers.
    assign o_valid = &full_s;
    assign fire_s  = o_valid && o_ready;

    for (genvar g = 0; g < N; g++) begin : g_lane
        pipeline_slot #(
            .W            (W),
            .BYPASS_READY (BYPASS_READY)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .in_valid (i_valid[g]),
            .in_ready (i_ready[g]),
            .in_data  (i_data[g]),
            .drain    (fire_s),
            .full     (full_s[g]),
            .data     (o_data[g])
        );
    end
endmodule

// File: tb/tb_pipeline_collect.sv
// Randomized and directed bench for pipeline_collect, checked against a
// per-lane occupancy model plus hand-computed expectations.
module tb_pipeline_collect;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // a: N=2 bypass, b: N=2 no bypass, c: N=4 bypass
    logic [1:0]       a_iv = 2'b00, a_ir, b_iv = 2'b00, b_ir;
    logic [1:0][31:0] a_id = '0, a_od, b_id = '0, b_od;
    logic             a_ov, a_ordy = 1'b0, b_ov, b_ordy = 1'b0;
    logic [3:0]       c_iv = 4'b0000, c_ir;
    logic [3:0][31:0] c_id = '0, c_od;
    logic             c_ov, c_ordy = 1'b0;

    pipeline_collect #(.N(2), .W(32), .BYPASS_READY(1)) dut_a (
        .clk(clk), .rst(rst), .i_valid(a_iv), .i_ready(a_ir), .i_data(a_id),
        .o_valid(a_ov), .o_ready(a_ordy), .o_data(a_od));
    pipeline_collect #(.N(2), .W(32), .BYPASS_READY(0)) dut_b (
        .clk(clk), .rst(rst), .i_valid(b_iv), .i_ready(b_ir), .i_data(b_id),
        .o_valid(b_ov), .o_ready(b_ordy), .o_data(b_od));
    pipeline_collect #(.N(4), .W(32), .BYPASS_READY(1)) dut_c (
        .clk(clk), .rst(rst), .i_valid(c_iv), .i_ready(c_ir), .i_data(c_id),
        .o_valid(c_ov), .o_ready(c_ordy), .o_data(c_od));

    int n_checks = 0;
    int n_errors = 0;

    // Model: which lanes currently hold an accepted payload, and its value.
    bit          mf [3][4];
    logic [31:0] mv [3][4];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk(input int id, input int n, input bit byp,
                       input logic [3:0] iv, input logic [3:0] ir, input logic [127:0] idat,
                       input logic ov, input logic ordy, input logic [127:0] odat);
        bit eov;
        bit fire;
        bit eir;
        if (!rst) begin
            for (int i = 0; i < 4; i++) mf[id][i] = 1'b0;
            cmp($sformatf("i%0d rst o_valid", id), {31'd0, ov}, 32'd0);
            for (int i = 0; i < n; i++) begin
                cmp($sformatf("i%0d rst i_ready%0d", id, i), {31'd0, ir[i]}, 32'd1);
                cmp($sformatf("i%0d rst o_data%0d", id, i), odat[i*32 +: 32], 32'd0);
            end
            return;
        end
        eov = 1'b1;
        for (int i = 0; i < n; i++) eov = eov && mf[id][i];
        cmp($sformatf("i%0d o_valid", id), {31'd0, ov}, {31'd0, eov});
        fire = eov && ordy;
        for (int i = 0; i < n; i++) begin
            eir = !mf[id][i] || (byp && fire);
            cmp($sformatf("i%0d i_ready%0d", id, i), {31'd0, ir[i]}, {31'd0, eir});
            if (mf[id][i])
                cmp($sformatf("i%0d o_data%0d", id, i), odat[i*32 +: 32], mv[id][i]);
            if (iv[i] && eir) begin
                mf[id][i] = 1'b1;
                mv[id][i] = idat[i*32 +: 32];
            end else if (fire) begin
                mf[id][i] = 1'b0;
            end
        end
    endtask

    // Per-cycle compare of every instance against the occupancy model.
    always @(negedge clk) begin
        chk(0, 2, 1'b1, {2'b00, a_iv}, {2'b00, a_ir}, {64'd0, a_id}, a_ov, a_ordy, {64'd0, a_od});
        chk(1, 2, 1'b0, {2'b00, b_iv}, {2'b00, b_ir}, {64'd0, b_id}, b_ov, b_ordy, {64'd0, b_od});
        chk(2, 4, 1'b1, c_iv, c_ir, c_id, c_ov, c_ordy, c_od);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_b2b(input int sel, input int exp_fires);
        int cnt, k, fires;
        logic [1:0] acc, ir;
        logic ov;
        logic [63:0] od;
        cnt = 1; k = 1; fires = 0;
        if (sel == 0) begin a_iv = 2'b11; a_id = {32'd1, 32'd1}; a_ordy = 1'b1; end
        else begin b_iv = 2'b11; b_id = {32'd1, 32'd1}; b_ordy = 1'b1; end
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (sel == 0) begin ov = a_ov; od = a_od; ir = a_ir; end
            else begin ov = b_ov; od = b_od; ir = b_ir; end
            if (ov) begin
                cmp($sformatf("b2b%0d lane0 #%0d", sel, k), od[31:0], 32'(k));
                cmp($sformatf("b2b%0d lane1 #%0d", sel, k), od[63:32], 32'(k));
                k++;
                fires++;
            end
            acc = ir;
            step();
            if (acc == 2'b11) begin
                cnt++;
                if (sel == 0) a_id = {32'(cnt), 32'(cnt)};
                else b_id = {32'(cnt), 32'(cnt)};
            end
        end
        cmp($sformatf("b2b%0d output count", sel), 32'(fires), 32'(exp_fires));
        a_iv = 2'b00; b_iv = 2'b00;
    endtask

    initial begin
        int seq [4];
        int fires, cyc;
        bit stall_prev;
        logic [3:0][31:0] prev_od;
        logic [3:0] acc;

        do_reset();

        // Async reset mid-run discards a partially collected lane.
        a_iv = 2'b01; a_id[0] = 32'h77;
        step();
        a_iv = 2'b00;
        cmp("partial i_ready", {30'd0, a_ir}, 32'd2);
        #2 rst = 1'b0;
        #1;
        cmp("async o_valid", {31'd0, a_ov}, 32'd0);
        cmp("async i_ready", {30'd0, a_ir}, 32'd3);
        cmp("async o_data", a_od[0], 32'd0);
        @(negedge clk);
        step();
        rst = 1'b1;
        a_iv = 2'b10; a_id[1] = 32'h88;
        step();
        a_iv = 2'b00;
        step();
        cmp("no stale o_valid", {31'd0, a_ov}, 32'd0);
        do_reset();

        // Latency: lane0 at cycle 1, lane1 at cycle 4, output at cycle 5.
        b_ordy = 1'b1;
        b_iv = 2'b01; b_id[0] = 32'hA5;
        step();
        b_iv = 2'b00;
        for (int c = 2; c <= 4; c++) begin
            cmp($sformatf("lat o_valid c%0d", c), {31'd0, b_ov}, 32'd0);
            cmp($sformatf("lat i_ready0 c%0d", c), {31'd0, b_ir[0]}, 32'd0);
            if (c == 4) begin b_iv = 2'b10; b_id[1] = 32'h3C; end
            step();
        end
        b_iv = 2'b00;
        cmp("lat o_valid c5", {31'd0, b_ov}, 32'd1);
        cmp("lat i_ready0 c5", {31'd0, b_ir[0]}, 32'd0);
        cmp("lat o_data0", b_od[0], 32'hA5);
        cmp("lat o_data1", b_od[1], 32'h3C);
        step();
        b_ordy = 1'b0;
        do_reset();

        run_b2b(0, 19);
        do_reset();
        run_b2b(1, 10);
        do_reset();

        // Output stall holds data and blocks both lanes; release refills.
        a_ordy = 1'b0; a_iv = 2'b11; a_id = {32'h22, 32'h11};
        step();
        a_id = {32'h44, 32'h33};
        for (int c = 0; c < 5; c++) begin
            cmp("stall o_valid", {31'd0, a_ov}, 32'd1);
            cmp("stall o_data0", a_od[0], 32'h11);
            cmp("stall o_data1", a_od[1], 32'h22);
            cmp("stall i_ready", {30'd0, a_ir}, 32'd0);
            step();
        end
        a_ordy = 1'b1;
        #1;
        cmp("release i_ready", {30'd0, a_ir}, 32'd3);
        step();
        a_iv = 2'b00;
        cmp("refill o_valid", {31'd0, a_ov}, 32'd1);
        cmp("refill o_data0", a_od[0], 32'h33);
        cmp("refill o_data1", a_od[1], 32'h44);
        step();
        a_ordy = 1'b0;
        do_reset();

        // Randomized N=4: per-lane sequence numbers must come out in order.
        for (int i = 0; i < 4; i++) seq[i] = 0;
        fires = 0; cyc = 0; stall_prev = 1'b0; prev_od = '0;
        c_ordy = 1'($urandom_range(0, 1));
        while (fires < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (stall_prev) begin
                cmp("rand stall o_valid", {31'd0, c_ov}, 32'd1);
                for (int i = 0; i < 4; i++)
                    cmp($sformatf("rand stall lane%0d", i), c_od[i], prev_od[i]);
            end
            if (c_ov && c_ordy) begin
                for (int i = 0; i < 4; i++)
                    cmp($sformatf("rand lane%0d #%0d", i, fires), c_od[i],
                        (32'(i) << 24) | 32'(fires));
                fires++;
            end
            stall_prev = c_ov && !c_ordy;
            prev_od = c_od;
            acc = c_iv & c_ir;
            step();
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    seq[i]++;
                    c_iv[i] = 1'b0;
                end
                if (!c_iv[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        c_iv[i] = 1'b1;
                        c_id[i] = (32'(i) << 24) | 32'(seq[i]);
                    end else begin
                        c_id[i] = $urandom;
                    end
                end
            end
            c_ordy = ($urandom_range(0, 3) != 0);
        end
        cmp("rand transactions", 32'(fires), 32'd1000);
        c_iv = 4'b0000; c_ordy = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
